// File: rtl/data_sram_bridge_pkg.sv
// Shared types and constants for the data-side CPU-to-sram-like bus bridge.
package data_sram_bridge_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/data_sram_bridge_wen_to_size.sv
// Maps CPU byte enables and byte address to the bus size, aligned address and direction.
module data_sram_bridge_wen_to_size
  import data_sram_bridge_pkg::*;
(
  input  logic [3:0]  wen_i,
  input  logic [31:0] addr_i,
  output logic        wr_o,
  output logic [1:0]  size_o,
  output logic [31:0] addr_o
);

  logic [1:0] addr_lo;
  logic       addr_lo_unused;

  // The low address bits are re-derived from the byte enables, never taken from the CPU.
  assign addr_lo_unused = ^addr_i[1:0];

  always_comb begin
    size_o  = SIZE_WORD;
    addr_lo = 2'd0;
    case (wen_i)
      4'b0001: begin size_o = SIZE_BYTE; addr_lo = 2'd0; end
      4'b0010: begin size_o = SIZE_BYTE; addr_lo = 2'd1; end
      4'b0100: begin size_o = SIZE_BYTE; addr_lo = 2'd2; end
      4'b1000: begin size_o = SIZE_BYTE; addr_lo = 2'd3; end
      4'b0011: begin size_o = SIZE_HALF; addr_lo = 2'd0; end
      4'b1100: begin size_o = SIZE_HALF; addr_lo = 2'd2; end
      default: begin size_o = SIZE_WORD; addr_lo = 2'd0; end
    endcase
  end

  assign wr_o   = |wen_i;
  assign addr_o = {addr_i[31:2], addr_lo};

endmodule

// File: rtl/data_sram_bridge.sv
// Data SRAM port to sram-like bus bridge, one outstanding transaction.
// Define DATA_BRIDGE_WBUF_EN to add a one-entry posted write buffer.
module data_sram_bridge
  import data_sram_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_en,
  input  logic [3:0]  cpu_wen,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        req,
  output logic        wr,
  output logic [1:0]  size,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  input  logic        addr_ok,
  input  logic        data_ok,
  input  logic [31:0] rdata
);

  state_e      state_q, state_d;
  logic        map_wr;
  logic [1:0]  map_size;
  logic [31:0] map_addr;
  logic        wr_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        issue;
  logic        done;
  logic        stall_release;

  data_sram_bridge_wen_to_size u_wen_to_size (
    .wen_i  (cpu_wen),
    .addr_i (cpu_addr),
    .wr_o   (map_wr),
    .size_o (map_size),
    .addr_o (map_addr)
  );

  assign issue = (state_q == S_IDLE) && cpu_en;
  assign done  = (state_q == S_DATA) && data_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (issue)   state_d = addr_ok ? S_DATA : S_ADDR;
      S_ADDR:  if (addr_ok) state_d = S_DATA;
      S_DATA:  if (data_ok) state_d = S_IDLE;
      default:              state_d = S_IDLE;
    endcase
  end

  // Capture on issue so the bus fields stay frozen until addr_ok and through DATA.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q    <= 1'b0;
      size_q  <= SIZE_BYTE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (issue) begin
        wr_q    <= map_wr;
        size_q  <= map_size;
        addr_q  <= map_addr;
        wdata_q <= cpu_wdata;
      end
      if (done && !wr_q) begin
        rdata_q <= rdata;
      end
    end
  end

`ifdef DATA_BRIDGE_WBUF_EN
  logic wb_q;
  logic post;

  // A posted store issues on the bus immediately; wb_q marks the in-flight
  // transaction as the buffered drain, which releases no CPU access.
  assign post = issue && map_wr && !wb_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_q <= 1'b0;
    end else if (post) begin
      wb_q <= 1'b1;
    end else if (done) begin
      wb_q <= 1'b0;
    end
  end

  assign stall_release = (done && !wb_q) || post;
`else
  assign stall_release = done;
`endif

  always_comb begin
    req       = issue || (state_q == S_ADDR);
    wr        = issue ? map_wr    : wr_q;
    size      = issue ? map_size  : size_q;
    addr      = issue ? map_addr  : addr_q;
    wdata     = issue ? cpu_wdata : wdata_q;
    cpu_rdata = done  ? rdata     : rdata_q;
    cpu_stall = cpu_en && !stall_release;
  end

endmodule
